// File: rtl/clken_gen.sv
// clken_gen: multi-channel fractional clock-enable generator.
// Each channel runs an ACC_W-bit phase accumulator. Every refclk edge it adds
// that channel's increment. The carry out becomes a one-cycle clock-enable
// pulse, and the accumulator MSB becomes a square wave with roughly 50% duty.
// A lock indicator asserts after LOCK_CYCLES edges with no configuration write
// and no align strobe.
//
// Ports:
//   refclk  in   1             sole clock, rising edge
//   rst     in   1             synchronous active-high reset
//   cfg_we  in   1             config write strobe (one cycle per write)
//   cfg_ch  in   CH_W          target channel; out-of-range writes are dropped
//   cfg_inc in   ACC_W         new phase increment
//   cfg_en  in   1             new channel enable
//   align   in   1             clears every accumulator (phase restart)
//   ce      out  NUM_CH        per-channel clock-enable pulse
//   outclk  out  NUM_CH        per-channel square wave
//   locked  out  1             configuration quiet for LOCK_CYCLES edges
module clken_gen #(
    parameter int unsigned               NUM_CH      = 2,
    parameter int unsigned               ACC_W       = 24,
    parameter logic [NUM_CH*ACC_W-1:0]   INC_INIT    = '0,
    parameter logic [NUM_CH-1:0]         EN_INIT     = '1,
    parameter int unsigned               LOCK_CYCLES = 16,
    localparam int unsigned              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              cfg_en,
    input  logic              align,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);

    localparam logic [15:0] LOCK_MAX = 16'(LOCK_CYCLES);

    logic [ACC_W-1:0] acc [NUM_CH];
    logic [ACC_W-1:0] inc [NUM_CH];
    logic [NUM_CH-1:0] en;
    logic [ACC_W:0]   sum [NUM_CH];
    logic [15:0]      lock_cnt;
    logic [15:0]      lock_cnt_nxt;

    // Widened sum: the top bit is the wrap carry that drives ce.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    always_comb begin
        lock_cnt_nxt = lock_cnt;
        if (cfg_we || align) begin
            lock_cnt_nxt = '0;
        end else if (lock_cnt != LOCK_MAX) begin
            lock_cnt_nxt = lock_cnt + 16'd1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                inc[i] <= INC_INIT[i*ACC_W +: ACC_W];
            end
            en       <= EN_INIT;
            ce       <= '0;
            outclk   <= '0;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (align || !en[i]) begin
                    acc[i]    <= '0;
                    ce[i]     <= 1'b0;
                    outclk[i] <= 1'b0;
                end else begin
                    acc[i]    <= sum[i][ACC_W-1:0];
                    ce[i]     <= sum[i][ACC_W];
                    outclk[i] <= sum[i][ACC_W-1];
                end
                // Config lands after this edge's accumulation, so it takes effect
                // from the next edge. Matching against each index in turn means an
                // out-of-range cfg_ch writes nothing.
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    inc[i] <= cfg_inc;
                    en[i]  <= cfg_en;
                end
            end
            lock_cnt <= lock_cnt_nxt;
            locked   <= (lock_cnt_nxt == LOCK_MAX);
        end
    end

endmodule

// File: tb/tb_clken_gen.sv
// Bench for clken_gen: 3 channels, 8-bit accumulators, and reset increments
// ch0=64, ch1=32, ch2=5. A behavioural model runs alongside the DUT and is
// compared on every falling edge. Literal expectations pin the model.
module tb_clken_gen;

    localparam int unsigned NCH  = 3;
    localparam int unsigned AW   = 8;
    localparam int unsigned LOCK = 16;
    localparam logic [NCH*AW-1:0] INIT_INC = 24'h05_20_40;
    localparam logic [NCH-1:0]    INIT_EN  = 3'b111;

    logic           refclk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [AW-1:0]  cfg_inc = '0;
    logic           cfg_en = 1'b0;
    logic           align = 1'b0;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] outclk;
    logic           locked;

    int n_checks = 0;
    int n_errors = 0;

    clken_gen #(
        .NUM_CH      (NCH),
        .ACC_W       (AW),
        .INC_INIT    (INIT_INC),
        .EN_INIT     (INIT_EN),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .refclk  (refclk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_inc (cfg_inc),
        .cfg_en  (cfg_en),
        .align   (align),
        .ce      (ce),
        .outclk  (outclk),
        .locked  (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. Phase is an integer count modulo 256. A pulse occurs
    // whenever the running phase passes 256. The square wave is high in the
    // upper half of the cycle.
    int             m_acc [NCH];
    int             m_inc [NCH];
    bit             m_en  [NCH];
    int             m_lc;
    logic [NCH-1:0] m_ce;
    logic [NCH-1:0] m_out;
    logic           m_locked;
    bit             m_valid = 1'b0;

    always @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = 0;
                m_inc[i] = int'(INIT_INC[i*AW +: AW]);
                m_en[i]  = INIT_EN[i];
            end
            m_ce = '0; m_out = '0; m_lc = 0; m_locked = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int i = 0; i < NCH; i++) begin
                if (align || !m_en[i]) begin
                    m_acc[i] = 0; m_ce[i] = 1'b0; m_out[i] = 1'b0;
                end else begin
                    int total;
                    total    = m_acc[i] + m_inc[i];
                    m_ce[i]  = (total >= 256);
                    m_acc[i] = total % 256;
                    m_out[i] = (m_acc[i] >= 128);
                end
            end
            if (cfg_we && int'(cfg_ch) < NCH) begin
                m_inc[cfg_ch] = int'(cfg_inc);
                m_en[cfg_ch]  = cfg_en;
            end
            if (cfg_we || align) m_lc = 0;
            else if (m_lc < LOCK) m_lc++;
            m_locked = (m_lc == LOCK);
        end
    end

    always @(negedge refclk) begin
        if (m_valid) begin
            check("model_ce", 32'(ce), 32'(m_ce));
            check("model_outclk", 32'(outclk), 32'(m_out));
            check("model_locked", 32'(locked), 32'(m_locked));
        end
    end

    task automatic cyc(input logic we, input logic [1:0] ch, input logic [AW-1:0] inc,
                       input logic en, input logic al);
        cfg_we = we; cfg_ch = ch; cfg_inc = inc; cfg_en = en; align = al;
        @(posedge refclk);
        #1;
        cfg_we = 1'b0; align = 1'b0;
    endtask

    task automatic quiet();
        cyc(1'b0, 2'd0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt0, cnt1, bad, adj;
        logic prev0;
        bit found;

        rst = 1'b1;
        repeat (2) @(posedge refclk);
        #1;
        check("reset_outputs", {29'd0, ce[0], outclk[0], locked}, 32'd0);
        check("reset_ce", 32'(ce), 32'd0);
        rst = 1'b0;

        // Edges 1..19 after reset release: check phase pattern and lock rise.
        for (int e = 1; e <= 19; e++) begin
            quiet();
            if (e == 2) check("e2_outclk", 32'(outclk), 32'b001);
            if (e == 4) begin
                check("e4_ce", 32'(ce), 32'b001);
                check("e4_outclk", 32'(outclk), 32'b010);
            end
            if (e == 8) begin
                check("e8_ce", 32'(ce), 32'b011);
                check("e8_outclk", 32'(outclk), 32'b000);
            end
            if (e == 15) check("lock_e15", 32'(locked), 32'd0);
            if (e == 16) check("lock_e16", 32'(locked), 32'd1);
        end
        // Edge 20: config write drops lock, then relock after 16 quiet edges.
        cyc(1'b1, 2'd0, 8'd64, 1'b1, 1'b0);
        check("lock_drop_cfg", 32'(locked), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            quiet();
            if (k == 15) check("relock_k15", 32'(locked), 32'd0);
            if (k == 16) check("relock_k16", 32'(locked), 32'd1);
        end

        // Align: ch1 (inc 32) pulses on every second ch0 (inc 64) pulse.
        cyc(1'b0, 2'd0, '0, 1'b0, 1'b1);
        check("align_clear", {29'd0, ce[0], outclk[0], locked}, 32'd0);
        cnt0 = 0; cnt1 = 0; bad = 0;
        for (int k = 1; k <= 32; k++) begin
            quiet();
            if (ce[0]) cnt0++;
            if (ce[1]) cnt1++;
            if (ce[1] && !ce[0]) bad++;
            if (ce[1] && (k % 8 != 0)) bad++;
        end
        check("align_ce0_count", cnt0, 8);
        check("align_ce1_count", cnt1, 4);
        check("align_coherent", bad, 0);

        // Out-of-range write: nothing changes, lock drops and relocks.
        cyc(1'b1, 2'd3, 8'd255, 1'b1, 1'b0);
        check("oor_lock_drop", 32'(locked), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            quiet();
            if (k == 16) check("oor_relock", 32'(locked), 32'd1);
        end

        // Disable ch1; outputs of ch1 go low on the following edge.
        cyc(1'b1, 2'd1, 8'd32, 1'b0, 1'b0);
        quiet();
        check("ch1_disabled", {30'd0, ce[1], outclk[1]}, 32'd0);

        // Write ch0 inc=3 together with align; count pulses.
        cyc(1'b1, 2'd0, 8'd3, 1'b1, 1'b1);
        cnt0 = 0; adj = 0; prev0 = 1'b0;
        for (int n = 1; n <= 2560; n++) begin
            quiet();
            if (ce[0]) cnt0++;
            if (ce[0] && prev0) adj++;
            prev0 = ce[0];
            if (n == 256) check("inc3_256", cnt0, 3);
        end
        check("inc3_2560", cnt0, 30);
        check("inc3_adjacent", adj, 0);

        // Reset while ce[0]=1 and locked=1 restores initial increments/enables.
        cyc(1'b1, 2'd0, 8'd128, 1'b1, 1'b0);
        repeat (16) quiet();
        check("pre_rst_locked", 32'(locked), 32'd1);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (ce[0]) found = 1'b1;
            else quiet();
        end
        check("pre_rst_ce0_seen", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge refclk);
        #1;
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_outclk", 32'(outclk), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            quiet();
            if (e == 2) check("post_rst_e2_ce", 32'(ce), 32'b000);
            if (e == 4) begin
                check("post_rst_e4_ce", 32'(ce), 32'b001);
                check("post_rst_e4_outclk", 32'(outclk), 32'b010);
            end
        end

        @(negedge refclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clken_gen.md
CLKEN_GEN -- requirements
Module: clken_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of output channels (1..8).
REQ-002 The block SHALL have parameter ACC_W, default 24, giving the phase-accumulator width (8..32).
REQ-003 The block SHALL have parameter INC_INIT, default all-zero, a NUM_CH*ACC_W packed vector of reset increments (channel i in bits [i*ACC_W +: ACC_W]).
REQ-004 The block SHALL have parameter EN_INIT, default all-ones, a NUM_CH-bit vector of reset channel enables.
REQ-005 The block SHALL have parameter LOCK_CYCLES, default 16, the quiet cycles required before locked asserts (1..65535).
REQ-006 refclk  in  1  sole clock; all logic is on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 cfg_we  in  1  config write strobe, one cycle per write.
REQ-009 cfg_ch  in  max(1,clog2(NUM_CH))  target channel of the write.
REQ-010 cfg_inc  in  ACC_W  new phase increment.
REQ-011 cfg_en  in  1  new channel enable.
REQ-012 align  in  1  phase-restart strobe for all channels.
REQ-013 ce  out  NUM_CH  per-channel single-cycle clock-enable pulse.
REQ-014 outclk  out  NUM_CH  per-channel ~50% duty square wave.
REQ-015 locked  out  1  all channels stable and phase-coherent.

Function
REQ-016 Each channel SHALL hold a registered ACC_W-bit accumulator acc[i], increment inc[i] and enable en[i].
REQ-017 On each edge with en[i]=1 and no align: {carry, acc_next} = acc[i] + inc[i] (ACC_W+1-bit sum), acc[i] <= acc_next, ce[i] <= carry, outclk[i] <= acc_next[ACC_W-1].
REQ-018 ce[i] SHALL be high for exactly one cycle per accumulator wrap, never two consecutive cycles unless inc[i] >= 2^(ACC_W-1) wraps on consecutive edges.
REQ-019 Output frequency of ce[i] SHALL equal f_refclk * inc[i] / 2^ACC_W exactly over long intervals (no cumulative drift).
REQ-020 inc[i]=0 with en[i]=1: acc[i], outclk[i] hold; ce[i]=0.
REQ-021 en[i]=0: acc[i] <= 0, ce[i] <= 0, outclk[i] <= 0 on every edge.
REQ-022 cfg_we=1 with cfg_ch < NUM_CH: inc[cfg_ch] <= cfg_inc and en[cfg_ch] <= cfg_en at that edge; new values are used from the next edge; acc is not cleared.
REQ-023 cfg_we=1 with cfg_ch >= NUM_CH: write ignored, but still counts as a config event for locked.
REQ-024 align=1: at that edge all acc[i] <= 0, all ce <= 0, all outclk <= 0; accumulation resumes on the next edge, so channels with commensurate increments are phase-coherent.
REQ-025 align and cfg_we in the same cycle: both apply; accumulators clear and the written increment is used from the next edge.
REQ-026 A lock counter SHALL count edges with rst=0, cfg_we=0, align=0, saturating at LOCK_CYCLES; any cfg_we or align clears it to 0 at that edge.
REQ-027 locked SHALL be registered, high exactly when the lock counter equals LOCK_CYCLES, and SHALL drop in the cycle after any cfg_we or align.
REQ-028 Channels are independent; a write to one channel SHALL NOT alter any other channel's acc, ce or outclk.

Reset
REQ-029 While rst=1 at an edge: acc[i] <= 0, inc[i] <= INC_INIT slice, en[i] <= EN_INIT bit, ce <= 0, outclk <= 0, lock counter <= 0, locked <= 0.
REQ-030 rst SHALL take priority over cfg_we and align; rst asserted mid-operation SHALL restore all reset values at that edge.
REQ-031 No output SHALL be X after the first edge with rst=1.

Verification
REQ-032 ACC_W=8, INC_INIT ch0=64, rst released: acc0 = 64,128,192,0 on edges 1-4; ce[0] high only after edges 4,8,12...; outclk[0] high after edges 2,3,6,7...
REQ-033 ACC_W=8, ch0 inc=64, ch1 inc=32, align pulsed: every ce[1] pulse coincides with every second ce[0] pulse, period 8 vs 4.
REQ-034 ACC_W=8, ch0 inc=3, 256 edges: exactly 3 ce[0] pulses, none adjacent; 2560 edges -> exactly 30.
REQ-035 LOCK_CYCLES=16: locked rises after exactly 16 quiet edges post-reset; cfg_we at edge 20 drops locked next cycle; relocks 16 quiet edges later.
REQ-036 Write cfg_ch=NUM_CH (out of range) inc=255: no channel changes, locked drops and relocks; write ch1 en=0: ce[1]=outclk[1]=0 next cycle, ch0 unaffected.
REQ-037 rst asserted while ce[0]=1 and locked=1: all outputs 0 after that edge; increments return to INC_INIT.
